// File: rtl/alu_serial_exec_if.sv
// Valid/ready operation and result channels for the digit-serial execute ALU.
// master drives operations and consumes results; slave is the ALU.
interface alu_serial_exec_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;

  modport master (
    output in_valid, alu_control, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );

  modport slave (
    input  in_valid, alu_control, src_a, src_b, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );
endinterface

// File: rtl/alu_serial_exec.sv
// Digit-serial execute-stage ALU: DIGIT bits per cycle LSB first, fixed WIDTH/DIGIT latency,
// result held under valid/ready until consumed.
module alu_serial_exec #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 4
) (
  input logic              clk,
  input logic              rst,
  alu_serial_exec_if.slave bus
);
  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("WIDTH must be a multiple of DIGIT");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
  logic [3:0]        op_q, op_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic              a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic              zero_q, zero_d, ill_q, ill_d;

  logic              sub_in, legal;
  logic [DIGIT:0]    sum;
  logic [DIGIT-1:0]  slice;
  logic [WIDTH-1:0]  shifted, final_res;
  logic              ovf, lt;

  assign bus.in_ready  = (state_q == StIdle) && !rst;
  assign bus.out_valid = (state_q == StDone);
  assign bus.result    = res_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = ill_q;

  assign sub_in = (bus.alu_control == 4'b0110) || (bus.alu_control == 4'b0111);

  always_comb begin
    sum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    case (op_q)
      4'b0000: slice = a_q[DIGIT-1:0] & b_q[DIGIT-1:0];
      4'b0001: slice = a_q[DIGIT-1:0] | b_q[DIGIT-1:0];
      default: slice = sum[DIGIT-1:0];
    endcase
    shifted = {slice, res_q[WIDTH-1:DIGIT]};
    // b_q holds ~B for SUB/SLT, so overflow uses the original B sign bit
    ovf = (a_msb_q != b_msb_q) && (shifted[WIDTH-1] != a_msb_q);
    lt  = shifted[WIDTH-1] ^ ovf;
    legal = 1'b1;
    case (op_q)
      4'b0000, 4'b0001, 4'b0010, 4'b0110: final_res = shifted;
      4'b0111: final_res = {{(WIDTH-1){1'b0}}, lt};
      default: begin
        final_res = '0;
        legal     = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    zero_d  = zero_q;
    ill_d   = ill_q;
    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          state_d = StRun;
          a_d     = bus.src_a;
          b_d     = sub_in ? ~bus.src_b : bus.src_b;
          op_d    = bus.alu_control;
          cnt_d   = '0;
          carry_d = sub_in;
          a_msb_d = bus.src_a[WIDTH-1];
          b_msb_d = bus.src_b[WIDTH-1];
        end
      end
      StRun: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = sum[DIGIT];
        cnt_d   = cnt_q + 1'b1;
        res_d   = shifted;
        if (cnt_q == CntW'(N - 1)) begin
          state_d = StDone;
          res_d   = final_res;
          zero_d  = (final_res == '0);
          ill_d   = !legal;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      zero_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      zero_q  <= zero_d;
      ill_q   <= ill_d;
    end
  end
endmodule

// File: tb/tb_alu_serial_exec.sv
// Bench for alu_serial_exec: arithmetic reference model checked every cycle, plus directed
// literal cases and randomized operations.
module tb_alu_serial_exec;
  localparam int unsigned W   = 32;
  localparam int unsigned LAT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  alu_serial_exec_if #(.WIDTH(W)) bus ();

  alu_serial_exec #(.WIDTH(W), .DIGIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Returns {illegal, zero, result}
  function automatic logic [W+1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [W-1:0] r;
    logic         ill;
    ill = 1'b0;
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: r = a + b;
      4'd6: r = a - b;
      4'd7: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: begin
        r   = '0;
        ill = 1'b1;
      end
    endcase
    return {ill, (r == '0), r};
  endfunction

  // Model: an accepted op appears LAT edges later and stays until out_ready is seen.
  int           m_cnt  = 0;
  logic         m_done = 1'b0;
  logic [W+1:0] m_pend = '0;
  logic [W+1:0] m_out  = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_out  <= '0;
    end else if (!m_done && m_cnt == 0) begin
      if (bus.in_valid) begin
        m_cnt  <= LAT;
        m_pend <= ref_alu(bus.alu_control, bus.src_a, bus.src_b);
      end
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_done <= 1'b1;
        m_out  <= m_pend;
      end
    end else if (bus.out_ready) begin
      m_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("in_ready", {31'b0, bus.in_ready}, {31'b0, (!rst && !m_done && m_cnt == 0)});
    chk("out_valid", {31'b0, bus.out_valid}, {31'b0, m_done});
    if (m_done) begin
      chk("result", bus.result, m_out[W-1:0]);
      chk("zero", {31'b0, bus.zero}, {31'b0, m_out[W]});
      chk("illegal", {31'b0, bus.illegal}, {31'b0, m_out[W+1]});
    end
  end

  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, output logic [W-1:0] res, output logic z,
                        output logic ill, output int lat);
    int wait_cnt;
    wait_cnt = 0;
    while (!bus.in_ready && wait_cnt < 40) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    if (!bus.in_ready) chk("accept_timeout", 32'd0, 32'd1);
    bus.in_valid    = 1'b1;
    bus.alu_control = op;
    bus.src_a       = a;
    bus.src_b       = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.out_valid) chk("done_timeout", 32'd0, 32'd1);
    res = bus.result;
    z   = bus.zero;
    ill = bus.illegal;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid    = 1'b1;
      bus.alu_control = 4'($urandom_range(0, 15));
      bus.src_a       = $urandom;
      bus.src_b       = $urandom;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    if (hold > 0) chk("hold_stable", bus.result, res);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] r;
    logic         z, il;
    int           lat;
    logic [W+1:0] p;
    logic [3:0]   codes [0:8];
    logic [W-1:0] a, b;

    codes = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd2, 4'd6, 4'd7, 4'd3};
    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b0;
    bus.alu_control = '0;
    bus.src_a       = '0;
    bus.src_b       = '0;

    p = ref_alu(4'd7, 32'h7FFF_FFFF, 32'h8000_0000);
    chk("model_slt_ovf", p[W-1:0], 32'd0);
    p = ref_alu(4'd6, 32'h0000_0003, 32'h0000_0005);
    chk("model_sub", p[W-1:0], 32'hFFFF_FFFE);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_result", bus.result, 32'd0);
    chk("rst_flags", {29'b0, bus.out_valid, bus.zero, bus.illegal}, 32'd0);
    chk("idle_in_ready", {31'b0, bus.in_ready}, 32'd1);

    run_op(4'd2, 32'h0000_0005, 32'h0000_0007, 0, r, z, il, lat);
    chk("add_latency", lat, LAT);
    chk("add_result", r, 32'h0000_000C);
    chk("add_zero", {31'b0, z}, 32'd0);
    run_op(4'd6, 32'h1234_5678, 32'h1234_5678, 0, r, z, il, lat);
    chk("sub_eq", {r[30:0], z}, 32'd1);
    run_op(4'd2, 32'hFFFF_FFFF, 32'h0000_0001, 0, r, z, il, lat);
    chk("add_wrap", {r[30:0], z}, 32'd1);
    run_op(4'd7, 32'hFFFF_FFFF, 32'h0000_0001, 0, r, z, il, lat);
    chk("slt_neg", r, 32'd1);
    run_op(4'd7, 32'h7FFF_FFFF, 32'h8000_0000, 0, r, z, il, lat);
    chk("slt_ovf", r, 32'd0);
    run_op(4'd0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, r, z, il, lat);
    chk("and", r, 32'h00F0_00F0);
    run_op(4'd1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5, r, z, il, lat);
    chk("or_held", r, 32'hFFF0_FFF0);
    run_op(4'd3, 32'h1234_5678, 32'h1111_1111, 0, r, z, il, lat);
    chk("illegal_lat", lat, LAT);
    chk("illegal_out", {r[29:0], z, il}, 32'd3);

    // Abort mid-RUN
    bus.in_valid    = 1'b1;
    bus.alu_control = 4'd2;
    bus.src_a       = 32'h0000_0100;
    bus.src_b       = 32'h0000_0023;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    chk("rst_mid_in_ready", {31'b0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort_result", bus.result, 32'd0);
    chk("abort_state", {30'b0, bus.out_valid, bus.in_ready}, 32'd1);
    run_op(4'd2, 32'h0000_0100, 32'h0000_0023, 0, r, z, il, lat);
    chk("after_abort", r, 32'h0000_0123);

    for (int k = 0; k < 60; k++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = a;
        1: a = 32'h8000_0000;
        2: b = 32'h7FFF_FFFF;
        default: ;
      endcase
      run_op(codes[$urandom_range(0, 8)], a, b, $urandom_range(0, 3), r, z, il, lat);
    end

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
